// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
// Single outstanding request: req/addr are level-held until a valid response returns.
interface fetch_stage_if;
  logic        req;
  logic [7:0]  addr;
  logic [15:0] rdata;
  logic        valid;

  modport master (
    output req,
    output addr,
    input  rdata,
    input  valid
  );

  modport slave (
    input  req,
    input  addr,
    output rdata,
    output valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake, absorbs stalls and redirects.
// Optional feature macro: FETCH_HALT_EN (fetch stops after delivering HALT_WORD).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | out of reset, no request yet
// S_FETCH | request outstanding at r_addr, waiting for imem valid
// S_DRAIN | redirect taken while a request was in flight; drop its response
// S_HOLD  | fetched word parked in hold buffer while pipeline is stalled
// S_HALT  | halt word delivered, no requests until redirect (FETCH_HALT_EN)
module fetch_stage #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_stall,
  input  logic          i_redirect,
  input  logic [7:0]    i_redirect_pc,
  fetch_stage_if.master imem,
  output logic [15:0]   o_ins_out,
  output logic          o_bubble_en,
  output logic [7:0]    o_pc_out,
  output logic          o_halted
);

`ifdef FETCH_HALT_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_HOLD, S_HALT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_HOLD} state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_pc;
  logic [7:0]  w_pc_nxt;
  logic [7:0]  w_pc_inc;
  logic        r_req;
  logic        w_req_nxt;
  logic [7:0]  r_addr;
  logic [7:0]  w_addr_nxt;
  logic [15:0] r_ins;
  logic        r_bubble;
  logic [7:0]  r_pc_out;
  logic [15:0] r_hold_buf;
  logic [15:0] w_hold_buf_nxt;
  logic        r_hold_vld;
  logic        w_hold_vld_nxt;
  logic        w_dlv;
  logic [15:0] w_dlv_word;

`ifdef FETCH_HALT_EN
  logic        r_halted;
  logic        w_halted_nxt;
  assign o_halted = r_halted;
`else
  logic        w_unused_halt_word;
  assign w_unused_halt_word = ^HALT_WORD;
  assign o_halted           = 1'b0;
`endif

  assign w_pc_inc    = r_pc + 8'd1;
  assign imem.req    = r_req;
  assign imem.addr   = r_addr;
  assign o_ins_out   = r_ins;
  assign o_bubble_en = r_bubble;
  assign o_pc_out    = r_pc_out;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_nxt      = r_req;
    w_addr_nxt     = r_addr;
    w_hold_buf_nxt = r_hold_buf;
    w_hold_vld_nxt = r_hold_vld;
    w_dlv          = 1'b0;
    w_dlv_word     = 16'h0000;
`ifdef FETCH_HALT_EN
    w_halted_nxt   = r_halted;
`endif

    if (i_redirect) begin
      // r_pc carries the redirect target; r_addr keeps the in-flight address while draining
      w_pc_nxt       = i_redirect_pc;
      w_hold_vld_nxt = 1'b0;
`ifdef FETCH_HALT_EN
      w_halted_nxt   = 1'b0;
`endif
      if (r_req && !imem.valid) begin
        w_state_nxt = S_DRAIN;
      end else begin
        w_state_nxt = S_FETCH;
        w_req_nxt   = 1'b1;
        w_addr_nxt  = i_redirect_pc;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_FETCH;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_pc;
        end
        S_FETCH: begin
          if (imem.valid) begin
            if (i_stall) begin
              w_state_nxt    = S_HOLD;
              w_req_nxt      = 1'b0;
              w_hold_buf_nxt = imem.rdata;
              w_hold_vld_nxt = 1'b1;
            end else begin
              w_dlv      = 1'b1;
              w_dlv_word = imem.rdata;
              w_pc_nxt   = w_pc_inc;
              w_req_nxt  = 1'b1;
              w_addr_nxt = w_pc_inc;
            end
          end
        end
        S_DRAIN: begin
          if (imem.valid) begin
            w_state_nxt = S_FETCH;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = r_pc;
          end
        end
        S_HOLD: begin
          if (!i_stall && r_hold_vld) begin
            w_dlv          = 1'b1;
            w_dlv_word     = r_hold_buf;
            w_hold_vld_nxt = 1'b0;
            w_pc_nxt       = w_pc_inc;
            w_state_nxt    = S_FETCH;
            w_req_nxt      = 1'b1;
            w_addr_nxt     = w_pc_inc;
          end
        end
`ifdef FETCH_HALT_EN
        S_HALT: begin
          w_req_nxt = 1'b0;
        end
`endif
        default: begin
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
        end
      endcase
    end

`ifdef FETCH_HALT_EN
    // the halt word itself still goes down the pipe; only further fetches stop
    if (w_dlv && (w_dlv_word == HALT_WORD)) begin
      w_state_nxt  = S_HALT;
      w_req_nxt    = 1'b0;
      w_halted_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_hold_buf <= 16'h0000;
      r_hold_vld <= 1'b0;
      r_ins      <= 16'h0000;
      r_bubble   <= 1'b1;
      r_pc_out   <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
      r_hold_buf <= w_hold_buf_nxt;
      r_hold_vld <= w_hold_vld_nxt;
      if (w_dlv) begin
        r_ins    <= w_dlv_word;
        r_pc_out <= r_pc;
        r_bubble <= 1'b0;
      end else begin
        r_ins    <= 16'h0000;
        r_bubble <= 1'b1;
      end
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_halted <= 1'b0;
    end else begin
      r_halted <= w_halted_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a latency-programmable imem model with a response budget,
// directed scenarios push expected deliveries, and a negedge monitor pops and compares.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [15:0] ins_out;
  logic        bubble_en;
  logic [7:0]  pc_out;
  logic        halted;

  fetch_stage_if bus ();

  fetch_stage dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .imem          (bus),
    .o_ins_out     (ins_out),
    .o_bubble_en   (bubble_en),
    .o_pc_out      (pc_out),
    .o_halted      (halted)
  );

  always #5 clk = ~clk;

  // imem model: answers after mem_lat cycles, but only while mem_served < mem_grant
  int   mem_lat    = 0;
  int   mem_grant  = 0;
  int   mem_served = 0;
  int   lat_cnt    = 0;
  logic halt_at3   = 1'b0;

  assign bus.valid = bus.req && (lat_cnt >= mem_lat) && (mem_served < mem_grant);
  assign bus.rdata = (halt_at3 && bus.addr == 8'h03) ? 16'hFFFF : 16'h1000 + {8'h00, bus.addr};

  always @(posedge clk) begin
    if (!bus.req || bus.valid) lat_cnt <= 0;
    else                       lat_cnt <= lat_cnt + 1;
    if (bus.valid) mem_served <= mem_served + 1;
  end

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  pc;
    int          gap;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_dlv = 0;
  logic mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [15:0] ins, input logic [7:0] pc, input int gap);
    exp_t e;
    e.ins = ins;
    e.pc  = pc;
    e.gap = gap;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (mon_en) begin
      if (bubble_en === 1'b0) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_delivery: got ins=%h pc=%h want no delivery", ins_out, pc_out);
        end else begin
          e = sb_q.pop_front();
          check("dlv_ins", 32'(ins_out), 32'(e.ins));
          check("dlv_pc", 32'(pc_out), 32'(e.pc));
          if (e.gap != 0) check("dlv_gap", 32'(cyc - last_dlv), 32'(e.gap));
        end
        last_dlv = cyc;
      end else begin
        check("bubble_ins_zero", 32'(ins_out), 32'h0);
      end
    end
  end

  task automatic wait_empty(input int bound);
    int n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    sb_q.delete();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    stall     = 1'b0;
    redirect  = 1'b0;
    mem_grant = mem_served;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(bus.req), 32'h0);
    check("rst_addr", 32'(bus.addr), 32'h00);
    check("rst_ins", 32'(ins_out), 32'h0);
    check("rst_bubble", 32'(bubble_en), 32'h1);
    check("rst_pc_out", 32'(pc_out), 32'h00);
    check("rst_halted", 32'(halted), 32'h0);
    sb_q.delete();
    rst = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;

    // zero-wait memory: one word per cycle from 00
    do_reset();
    mon_en  = 1'b1;
    mem_lat = 0;
    expect_word(16'h1000, 8'h00, 0);
    expect_word(16'h1001, 8'h01, 1);
    expect_word(16'h1002, 8'h02, 1);
    mem_grant = mem_served + 3;
    wait_empty(40);
    check("t1_next_addr", 32'(bus.addr), 32'h03);
    check("t1_req", 32'(bus.req), 32'h1);

    expect_word(16'h1003, 8'h03, 0);
    expect_word(16'h1004, 8'h04, 1);
    mem_grant = mem_grant + 2;
    wait_empty(40);

    // stall for 3 cycles while 1005 returns
    check("t3_pre_addr", 32'(bus.addr), 32'h05);
    stall = 1'b1;
    expect_word(16'h1005, 8'h05, 0);
    mem_grant = mem_grant + 1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 3) stall = 1'b0;
      check("t3_hold_bubble", 32'(bubble_en), 32'h1);
      check("t3_hold_req", 32'(bus.req), 32'h0);
    end
    @(negedge clk);
    check("t3_release_bubble", 32'(bubble_en), 32'h0);
    check("t3_release_req", 32'(bus.req), 32'h1);
    check("t3_release_addr", 32'(bus.addr), 32'h06);
    wait_empty(5);

    // two-cycle memory: one word then two bubbles
    do_reset();
    mem_lat = 2;
    expect_word(16'h1000, 8'h00, 0);
    expect_word(16'h1001, 8'h01, 3);
    expect_word(16'h1002, 8'h02, 3);
    expect_word(16'h1003, 8'h03, 3);
    mem_grant = mem_served + 4;
    wait_empty(60);

    // redirect to 40 with a 3-cycle request in flight
    do_reset();
    mem_lat = 3;
    @(negedge clk);
    check("t4_req0", 32'(bus.req), 32'h1);
    check("t4_addr0", 32'(bus.addr), 32'h00);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    mem_grant   = mem_grant + 1;
    @(negedge clk);
    redirect = 1'b0;
    check("t4_drain_bubble", 32'(bubble_en), 32'h1);
    check("t4_drain_req", 32'(bus.req), 32'h1);
    check("t4_drain_addr", 32'(bus.addr), 32'h00);
    repeat (3) @(negedge clk);
    check("t4_new_addr", 32'(bus.addr), 32'h40);
    check("t4_new_req", 32'(bus.req), 32'h1);
    check("t4_new_bubble", 32'(bubble_en), 32'h1);
    expect_word(16'h1040, 8'h40, 0);
    mem_grant = mem_grant + 1;
    wait_empty(30);

    // PC wrap FE, FF, 00 (redirect drains the pending fetch of 41 first)
    redirect    = 1'b1;
    redirect_pc = 8'hFE;
    mem_lat     = 0;
    @(negedge clk);
    redirect = 1'b0;
    check("t5_drain_addr", 32'(bus.addr), 32'h41);
    expect_word(16'h10FE, 8'hFE, 0);
    expect_word(16'h10FF, 8'hFF, 1);
    expect_word(16'h1000, 8'h00, 1);
    mem_grant = mem_grant + 4;
    wait_empty(30);
    check("t5_next_addr", 32'(bus.addr), 32'h01);

    // redirect beats a held word and an active stall
    stall     = 1'b1;
    mem_grant = mem_grant + 1;
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 8'h20;
    @(negedge clk);
    redirect = 1'b0;
    stall    = 1'b0;
    check("t5b_bubble", 32'(bubble_en), 32'h1);
    check("t5b_addr", 32'(bus.addr), 32'h20);
    check("t5b_req", 32'(bus.req), 32'h1);
    expect_word(16'h1020, 8'h20, 0);
    mem_grant = mem_grant + 1;
    wait_empty(20);

    // halt word at address 03
    do_reset();
    mem_lat  = 0;
    halt_at3 = 1'b1;
    expect_word(16'h1000, 8'h00, 0);
    expect_word(16'h1001, 8'h01, 1);
    expect_word(16'h1002, 8'h02, 1);
    expect_word(16'hFFFF, 8'h03, 1);
`ifdef FETCH_HALT_EN
    mem_grant = mem_served + 6;
    wait_empty(40);
    for (int i = 0; i < 3; i++) begin
      check("t6_halted", 32'(halted), 32'h1);
      check("t6_halt_req", 32'(bus.req), 32'h0);
      check("t6_halt_bubble", 32'(bubble_en), 32'h1);
      @(negedge clk);
    end
    mem_grant   = mem_served + 1;
    redirect    = 1'b1;
    redirect_pc = 8'h10;
    expect_word(16'h1010, 8'h10, 0);
    @(negedge clk);
    redirect = 1'b0;
    check("t6_resume_halted", 32'(halted), 32'h0);
    check("t6_resume_addr", 32'(bus.addr), 32'h10);
    check("t6_resume_req", 32'(bus.req), 32'h1);
    wait_empty(20);
`else
    expect_word(16'h1004, 8'h04, 1);
    mem_grant = mem_served + 5;
    wait_empty(40);
    check("t6_not_halted", 32'(halted), 32'h0);
    check("t6_next_addr", 32'(bus.addr), 32'h05);
    check("t6_next_req", 32'(bus.req), 32'h1);
`endif
    halt_at3 = 1'b0;

    // reset with a request outstanding: restart from RESET_PC
    do_reset();
    @(negedge clk);
    check("t7_first_req", 32'(bus.req), 32'h1);
    check("t7_first_addr", 32'(bus.addr), 32'h00);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
